// File: rtl/irq_scheduler.sv
// irq_scheduler: memory-mapped interrupt controller. It latches and masks
// peripheral requests, then raises a single fixed-priority request to the
// core and holds it until the core acknowledges. Further requests stay
// blocked until the handler returns.
module irq_scheduler #(
  parameter int          N_SRC     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h40000030
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             rd,
  input  logic             wr,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             irq,
  input  logic             irq_ack,
  input  logic             eret,
  output logic [2:0]       irq_id,
  output logic             in_service
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       irqId_q, irqId_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] edge_q, edge_d;
  logic [N_SRC-1:0] prevSrc_q;

  logic             winHit;
  logic [1:0]       regSel;
  logic [N_SRC-1:0] riseBits;
  logic [N_SRC-1:0] w1cBits;
  logic [N_SRC-1:0] ackBits;
  logic [N_SRC-1:0] eligible;
  logic [2:0]       winner;
  logic             unusedBits;

  assign winHit     = (addr[31:4] == BASE_ADDR[31:4]);
  assign regSel     = addr[3:2];
  assign riseBits   = irq_src & ~prevSrc_q;
  assign eligible   = pend_q & mask_q;
  assign irq_id     = irqId_q;
  assign unusedBits = ^{addr[1:0], wdata[31:N_SRC]};

  // Work out which pending bits get cleared this cycle (software W1C or
  // the core acknowledging the latched source).
  always_comb begin
    w1cBits = '0;
    ackBits = '0;
    if (wr && winHit && (regSel == 2'd0)) begin
      w1cBits = wdata[N_SRC-1:0];
    end
    for (int i = 0; i < N_SRC; i++) begin
      if ((state_q == REQ) && irq_ack && (irqId_q == 3'(i))) begin
        ackBits[i] = 1'b1;
      end
    end
  end

  // Pending and config next-state: edge bits set on rising edge (set beats
  // clear), level bits simply follow the registered source level.
  always_comb begin
    pend_d = (edge_q & ((pend_q & ~(w1cBits | ackBits)) | riseBits))
           | (~edge_q & irq_src);
    mask_d = mask_q;
    edge_d = edge_q;
    if (wr && winHit && (regSel == 2'd1)) begin
      mask_d = wdata[N_SRC-1:0];
    end
    if (wr && winHit && (regSel == 2'd3)) begin
      edge_d = wdata[N_SRC-1:0];
    end
  end

  // Fixed priority: the lowest eligible index wins.
  always_comb begin
    winner = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner = 3'(i);
      end
    end
  end

  // Request FSM: a latched request stays committed until acked, and no new
  // request is raised while a handler is running.
  always_comb begin
    state_d    = state_q;
    irqId_d    = irqId_q;
    irq        = 1'b0;
    in_service = 1'b0;
    case (state_q)
      IDLE: begin
        if (eligible != '0) begin
          irqId_d = winner;
          state_d = REQ;
        end
      end
      REQ: begin
        irq = 1'b1;
        if (irq_ack) begin
          state_d = SERVICE;
        end
      end
      SERVICE: begin
        in_service = 1'b1;
        if (eret) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus read mux; anything outside the window or without rd reads as zero.
  always_comb begin
    rdata = 32'h0;
    if (rd && winHit) begin
      case (regSel)
        2'd0:    rdata = 32'(pend_q);
        2'd1:    rdata = 32'(mask_q);
        2'd2:    rdata = {in_service, irq, 27'b0, irqId_q};
        default: rdata = 32'(edge_q);
      endcase
    end
  end

  // State registers; reset wipes every request and configuration bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      irqId_q   <= 3'd0;
      pend_q    <= '0;
      mask_q    <= '0;
      edge_q    <= '0;
      prevSrc_q <= '0;
    end else begin
      state_q   <= state_d;
      irqId_q   <= irqId_d;
      pend_q    <= pend_d;
      mask_q    <= mask_d;
      edge_q    <= edge_d;
      prevSrc_q <= irq_src;
    end
  end

endmodule

// File: tb/tb_irq_scheduler.sv
// tb_irq_scheduler: directed vectors with hand-computed expectations.
module tb_irq_scheduler;

  localparam logic [31:0] PEND_A  = 32'h40000030;
  localparam logic [31:0] MASK_A  = 32'h40000034;
  localparam logic [31:0] CAUSE_A = 32'h40000038;
  localparam logic [31:0] EDGE_A  = 32'h4000003C;

  logic        clk;
  logic        reset;
  logic [3:0]  irqSrc;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;
  logic        irqAck;
  logic        eret;
  logic [2:0]  irqId;
  logic        inService;

  int testCount;
  int failCount;

  irq_scheduler #(.N_SRC(4), .BASE_ADDR(32'h40000030)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_src    (irqSrc),
    .rd         (rd),
    .wr         (wr),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .irq        (irq),
    .irq_ack    (irqAck),
    .eret       (eret),
    .irq_id     (irqId),
    .in_service (inService)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so a stuck run still ends with a report.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
    wr = 1'b1;
    addr = a;
    wdata = d;
    tick();
    wr = 1'b0;
  endtask

  task automatic busRead(input logic [31:0] a, output logic [31:0] d);
    rd = 1'b1;
    addr = a;
    #1;
    d = rdata;
    rd = 1'b0;
  endtask

  task automatic applyStimulus(input logic ack, input logic ret);
    irqAck = ack;
    eret = ret;
    tick();
    irqAck = 1'b0;
    eret = 1'b0;
  endtask

  task automatic pulseSrc(input logic [3:0] bits);
    irqSrc = bits;
    tick();
    irqSrc = 4'h0;
  endtask

  initial begin
    logic [31:0] r;
    testCount = 0;
    failCount = 0;
    reset = 1'b0;
    irqSrc = 4'h0;
    rd = 1'b0;
    wr = 1'b0;
    addr = 32'h0;
    wdata = 32'h0;
    irqAck = 1'b0;
    eret = 1'b0;
    #23;
    checkOutput("rst_irq", 32'(irq), 32'h0);
    checkOutput("rst_insvc", 32'(inService), 32'h0);
    checkOutput("rst_id", 32'(irqId), 32'h0);
    busRead(PEND_A, r);
    checkOutput("rst_pend", r, 32'h0);
    checkOutput("rst_rdata_idle", rdata, 32'h0);
    reset = 1'b1;
    tick();

    // Edge on source 1 with MASK=0011, EDGE=1111
    busWrite(MASK_A, 32'h3);
    busWrite(EDGE_A, 32'hF);
    pulseSrc(4'b0010);
    checkOutput("t1_irq_early", 32'(irq), 32'h0);
    busRead(PEND_A, r);
    checkOutput("t1_pend_set", r, 32'h2);
    tick();
    checkOutput("t1_irq", 32'(irq), 32'h1);
    busRead(CAUSE_A, r);
    checkOutput("t1_cause_req", r, 32'h40000001);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t1_irq_after_ack", 32'(irq), 32'h0);
    checkOutput("t1_insvc", 32'(inService), 32'h1);
    busRead(PEND_A, r);
    checkOutput("t1_pend_acked", r, 32'h0);
    busRead(CAUSE_A, r);
    checkOutput("t1_cause_svc", r, 32'h80000001);
    applyStimulus(1'b0, 1'b1);
    checkOutput("t1_insvc_eret", 32'(inService), 32'h0);
    checkOutput("t1_id_held", 32'(irqId), 32'h1);

    // Simultaneous edges on sources 0 and 2
    busWrite(MASK_A, 32'hF);
    pulseSrc(4'b0101);
    tick();
    checkOutput("t2_irq_a", 32'(irq), 32'h1);
    checkOutput("t2_id_a", 32'(irqId), 32'h0);
    applyStimulus(1'b1, 1'b0);
    busRead(PEND_A, r);
    checkOutput("t2_pend_left", r, 32'h4);
    tick();
    checkOutput("t2_no_nest", 32'(irq), 32'h0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("t2_idle_gap", 32'(irq), 32'h0);
    tick();
    checkOutput("t2_irq_b", 32'(irq), 32'h1);
    checkOutput("t2_id_b", 32'(irqId), 32'h2);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);

    // Level source 3
    busWrite(EDGE_A, 32'h7);
    irqSrc = 4'b1000;
    tick();
    tick();
    checkOutput("t3_irq", 32'(irq), 32'h1);
    checkOutput("t3_id", 32'(irqId), 32'h3);
    busWrite(PEND_A, 32'h8);
    busRead(PEND_A, r);
    checkOutput("t3_w1c_level", r, 32'h8);
    applyStimulus(1'b1, 1'b0);
    busRead(PEND_A, r);
    checkOutput("t3_ack_level", r, 32'h8);
    applyStimulus(1'b0, 1'b1);
    tick();
    checkOutput("t3_rerequest", 32'(irq), 32'h1);
    irqSrc = 4'b0000;
    tick();
    tick();
    checkOutput("t3_committed", 32'(irq), 32'h1);
    checkOutput("t3_committed_id", 32'(irqId), 32'h3);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    tick();
    checkOutput("t3_quiet", 32'(irq), 32'h0);

    // Edge on source 1 during SERVICE, then ack+eret together in REQ
    pulseSrc(4'b0001);
    tick();
    applyStimulus(1'b1, 1'b0);
    checkOutput("t4_insvc", 32'(inService), 32'h1);
    pulseSrc(4'b0010);
    tick();
    busRead(PEND_A, r);
    checkOutput("t4_pend_svc", r, 32'h2);
    checkOutput("t4_irq_blocked", 32'(irq), 32'h0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("t4_idle_gap", 32'(irq), 32'h0);
    tick();
    checkOutput("t4_irq_after", 32'(irq), 32'h1);
    checkOutput("t4_id", 32'(irqId), 32'h1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("t4_ackret_svc", 32'(inService), 32'h1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("t4_ackret_done", 32'(inService), 32'h0);

    // Same-cycle W1C and new edge on source 2
    busWrite(MASK_A, 32'h0);
    irqSrc = 4'b0100;
    busWrite(PEND_A, 32'h4);
    irqSrc = 4'b0000;
    busRead(PEND_A, r);
    checkOutput("t5_set_wins", r, 32'h4);
    busWrite(PEND_A, 32'h4);
    busRead(PEND_A, r);
    checkOutput("t5_w1c", r, 32'h0);

    // Window decode and unused upper bits
    busWrite(MASK_A, 32'hFFFFFFFF);
    busRead(MASK_A, r);
    checkOutput("t6_mask_bits", r, 32'hF);
    busRead(32'h40000044, r);
    checkOutput("t6_outside", r, 32'h0);
    addr = MASK_A;
    #1;
    checkOutput("t6_no_rd", rdata, 32'h0);

    // Asynchronous reset while a request is pending
    pulseSrc(4'b0100);
    tick();
    checkOutput("t7_irq_req", 32'(irq), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t7_irq", 32'(irq), 32'h0);
    checkOutput("t7_insvc", 32'(inService), 32'h0);
    checkOutput("t7_id", 32'(irqId), 32'h0);
    busRead(PEND_A, r);
    checkOutput("t7_pend", r, 32'h0);
    busRead(MASK_A, r);
    checkOutput("t7_mask", r, 32'h0);
    reset = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/irq_scheduler.md
# irq_scheduler

Memory-mapped interrupt controller between the peripheral interrupt sources (timer, UART send/receive, spare) and the processor core's single `Interrupt` input. It latches and masks requests and picks one by fixed priority. It holds the request until the core acknowledges the jump to the interrupt vector, then blocks further requests until the handler returns. It sits on the peripheral bus beside `Peripheral`, and its read data is OR-combined into `ReadData`.

## Interface
- `N_SRC`, 4, number of interrupt sources (1..8); index 0 has the highest priority.
- `BASE_ADDR`, 32'h40000030, word-aligned base of the 4-word register window.

- `clk`  in  1  core clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-low reset; clears all state immediately.
- `irq_src`  in  N_SRC  source request lines, synchronous to `clk`.
- `rd`  in  1  bus read enable.
- `wr`  in  1  bus write enable.
- `addr`  in  32  bus byte address.
- `wdata`  in  32  bus write data.
- `rdata`  out  32  bus read data, combinational.
- `irq`  out  1  interrupt request to the core.
- `irq_ack`  in  1  one-cycle pulse when the core redirects PC to 32'h80000004.
- `eret`  in  1  one-cycle pulse when the handler returns.
- `irq_id`  out  3  index of the latched or serviced source.
- `in_service`  out  1  high while a handler is active.

## Operation
- Registers are word-selected by `addr[3:2]` when `addr[31:4] == BASE_ADDR[31:4]`:
  - +0x0 PEND: read returns pending bits. A write with 1 clears the corresponding edge-mode bits (W1C).
  - +0x4 MASK: read/write. A 1 enables the source. Reset value 0.
  - +0x8 CAUSE: read-only, `{in_service, irq, 27'b0, irq_id}`.
  - +0xC EDGE: read/write. 1 = edge-triggered, 0 = level. Reset value 0.
- `rdata` = selected register when `rd` is high and the address hits the window, else 32'h0.
- Writes take effect at the posedge with `wr` high. Bits above `N_SRC` read as 0 and are ignored on write.
- `prev_src` register samples `irq_src` every cycle.
- Edge-mode sources:
  - PEND bit sets when `irq_src & ~prev_src`.
  - It clears by W1C, or by `irq_ack` for the latched id.
  - If set and clear occur in the same cycle, set wins.
- Level-mode sources: PEND bit equals the registered `irq_src` level; W1C and ack have no effect.
- `eligible` = PEND & MASK. The winner is the lowest set index.
- FSM states:
  - IDLE: `irq` = 0, `in_service` = 0. If `eligible` is nonzero, latch the winner into `irq_id` and go to REQ.
  - REQ: `irq` = 1. The request is committed: it is held even if the source is masked or drops. On `irq_ack`, clear the edge-mode PEND bit for `irq_id`, go to SERVICE, `irq` = 0.
  - SERVICE: `in_service` = 1 and no new request is raised (no nesting). On `eret`, go to IDLE; `irq_id` is held.
- Ignored events:
  - `irq_ack` outside REQ.
  - `eret` outside SERVICE.
  - `irq_ack` and `eret` arriving together in REQ: only the ack is taken.
- Arbitration and MASK/EDGE writes never alter a latched `irq_id`.

## Timing
- Reset values:
  - `irq` = 0, `in_service` = 0, `irq_id` = 0.
  - PEND, MASK, EDGE, `prev_src` all 0.
  - FSM = IDLE; `rdata` = 0 when there is no read.
- Reset asserted mid-operation returns immediately to IDLE with all outputs cleared. No pending state survives.
- Source rising edge at posedge T: PEND bit set at T+1, FSM enters REQ at T+2, `irq` high during cycle T+2.
- Eligible bit present in IDLE at posedge T: `irq` high after T. Latency is 1 cycle from `eligible`.
- `irq_ack` sampled at posedge T: `irq` low and `in_service` high after T.
- `eret` sampled at posedge T: IDLE after T. If a request is already eligible, REQ after T+1, so there is one IDLE cycle between handlers.
- A MASK write at T affects `eligible` from T+1.
- `rdata` is combinational in the same cycle as `rd`.

## Test plan
- Reset mid-REQ: pull `reset` low -> `irq`, `in_service`, PEND and MASK are 0 without waiting for a clock edge.
- MASK = 4'b0011, EDGE = 4'b1111, pulse `irq_src[1]`:
  - `irq` = 1 two cycles after the edge, CAUSE = 32'h40000001.
  - Ack -> PEND[1] = 0, `in_service` = 1.
  - `eret` -> IDLE.
- Edges on sources 2 and 0 in the same cycle, MASK = 4'hF:
  - First service has `irq_id` = 0.
  - After `eret`, second service has `irq_id` = 2 after one IDLE cycle.
- Level source 3, MASK[3] = 1:
  - Hold `irq_src[3]` high -> W1C to PEND has no effect; re-requests after each `eret`.
  - Drop it during REQ -> request stays committed until ack.
- Edge on source 1 during SERVICE -> PEND[1] = 1 but `irq` stays 0 until `eret`, then asserts.
- Same-cycle W1C of PEND[2] and new edge on source 2 -> PEND[2] remains 1.
- Read of an address outside the window -> `rdata` = 0.
